// File: rtl/zip_busarb.sv
// Two-master pipelined Wishbone arbiter: round-robin grant held until the owner drops CYC,
// outstanding-request tracking with a MAXPEND stall, and a watchdog that aborts a stuck slave.
module zip_busarb #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int LGPEND  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_stall,
  input  logic            i_ack,
  input  logic            i_err
);

  localparam logic [LGPEND-1:0] MAXPEND  = '1;
  localparam int                WDW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0]    WD_LIMIT = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [LGPEND-1:0] pend_q, pend_d;
  logic [WDW-1:0]    wdog_q, wdog_d;

  logic own_a, own_b, own_cyc, own_stb, full, ack_ok, accept;

  always_comb begin
    own_a   = (state_q == S_OWN_A);
    own_b   = (state_q == S_OWN_B);
    full    = (pend_q == MAXPEND);
    // An ACK with nothing outstanding is stray and must not reach either master
    ack_ok  = i_ack && (pend_q != '0);
    own_cyc = (own_a && i_a_cyc) || (own_b && i_b_cyc);
    own_stb = (own_a && i_a_stb) || (own_b && i_b_stb);
  end

  always_comb begin
    o_cyc  = own_cyc;
    o_stb  = own_cyc && own_stb && !full;
    o_we   = 1'b0;
    o_addr = '0;
    o_data = '0;
    o_sel  = '0;
    if (own_a) begin
      o_we   = i_a_we;
      o_addr = i_a_addr;
      o_data = i_a_data;
      o_sel  = i_a_sel;
    end else if (own_b) begin
      o_we   = i_b_we;
      o_addr = i_b_addr;
      o_data = i_b_data;
      o_sel  = i_b_sel;
    end else begin
      o_we   = 1'b0;
    end
    accept    = o_stb && !i_stall;
    o_a_stall = own_a ? (i_stall || full) : 1'b1;
    o_b_stall = own_b ? (i_stall || full) : 1'b1;
    o_a_ack   = own_a && ack_ok;
    o_b_ack   = own_b && ack_ok;
    // In ABORT the last-granted bit still names the master that was cut off
    o_a_err   = (own_a && i_err) || ((state_q == S_ABORT) && !last_b_q);
    o_b_err   = (own_b && i_err) || ((state_q == S_ABORT) && last_b_q);
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    pend_d   = pend_q;
    wdog_d   = '0;
    case (state_q)
      S_IDLE: begin
        pend_d = '0;
        if (i_a_cyc && (!i_b_cyc || last_b_q)) begin
          state_d  = S_OWN_A;
          last_b_d = 1'b0;
        end else if (i_b_cyc) begin
          state_d  = S_OWN_B;
          last_b_d = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_OWN_A, S_OWN_B: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          pend_d  = '0;
        end else if ((TIMEOUT != 0) && (wdog_q == WD_LIMIT)) begin
          state_d = S_ABORT;
          pend_d  = '0;
        end else if (i_err) begin
          pend_d  = '0;
        end else begin
          pend_d = pend_q + LGPEND'(accept) - LGPEND'(ack_ok);
          if ((TIMEOUT != 0) && (pend_q != '0) && !i_ack) begin
            wdog_d = wdog_q + WDW'(1);
          end else begin
            wdog_d = '0;
          end
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        pend_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      last_b_q <= 1'b1;
      pend_q   <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      pend_q   <= pend_d;
      wdog_q   <= wdog_d;
    end
  end

endmodule
